// File: rtl/gpr_hazard_tracker_pkg.sv
// Shared types for the GPR hazard tracker: result classes, address width and
// the pipeline slot record carried through EXE and MEM.
package gpr_hazard_tracker_pkg;

    localparam int GPR_ADDR_W = 5;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

    // When an instruction's result becomes available for forwarding.
    typedef enum logic [1:0] {
        GPR_CLASS_NONE = 2'd0,  // writes no GPR
        GPR_CLASS_EXE  = 2'd1,  // ALU result, ready in EXE
        GPR_CLASS_MEM  = 2'd2,  // load result, ready in MEM
        GPR_CLASS_LONG = 2'd3   // mul/div result, ready when the unit is done
    } gpr_class_e;

    typedef struct packed {
        logic       valid;
        gpr_class_e wclass;
        gpr_addr_t  waddr;
    } gpr_slot_t;

    localparam gpr_slot_t GPR_SLOT_EMPTY = '{valid: 1'b0, wclass: GPR_CLASS_NONE, waddr: '0};

    // Build the slot for an instruction leaving ID; a NONE writer carries
    // address 0 so it can never match a reader.
    function automatic gpr_slot_t gpr_slot_from_id(gpr_class_e wclass, gpr_addr_t waddr);
        gpr_slot_t slot;
        slot.valid  = 1'b1;
        slot.wclass = wclass;
        slot.waddr  = (wclass == GPR_CLASS_NONE) ? '0 : waddr;
        return slot;
    endfunction

endpackage

// File: rtl/gpr_hazard_tracker_src_check.sv
// One source-operand hazard comparator: the operand depends on the EXE writer
// and that writer's result cannot be forwarded yet.
module gpr_src_check
    import gpr_hazard_tracker_pkg::*;
(
    input  logic      i_ren,
    input  gpr_addr_t i_raddr,
    input  logic      i_exe_valid,
    input  gpr_addr_t i_exe_waddr,
    input  logic      i_exe_ready,
    output logic      o_hazard
);

    // $0 is hard-wired zero and never creates a dependency.
    assign o_hazard = i_ren && (i_raddr != '0) && i_exe_valid
                   && (i_exe_waddr == i_raddr) && !i_exe_ready;

endmodule

// File: rtl/gpr_hazard_tracker.sv
// Tracks in-flight GPR writers in EXE, MEM and WB, publishes the forwarding
// metadata for the bypass, and raises the ID stall for load-use and mul/div
// dependencies that forwarding cannot cover.
module gpr_hazard_tracker
    import gpr_hazard_tracker_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ID_valid,
    input  logic [1:0]            i_ID_wclass,
    input  logic [GPR_ADDR_W-1:0] i_ID_waddr,
    input  logic                  i_ID_ren1,
    input  logic                  i_ID_ren2,
    input  logic [GPR_ADDR_W-1:0] i_ID_raddr1,
    input  logic [GPR_ADDR_W-1:0] i_ID_raddr2,
    input  logic                  i_LONG_done,
    input  logic                  i_flush,
    output logic                  o_ID_stall,
    output logic                  o_EXE_hold,
    output logic                  o_LONG_abort,
    output logic                  o_EXE_get_result_in_EXE,
    output logic [GPR_ADDR_W-1:0] o_EXE_waddr,
    output logic                  o_MEM_get_result_in_MEM,
    output logic [GPR_ADDR_W-1:0] o_MEM_waddr,
    output logic                  o_WB_wen,
    output logic [GPR_ADDR_W-1:0] o_WB_waddr,
    output logic [31:0]           o_stall_cycles
);

    gpr_slot_t   exe_q, exe_d;
    gpr_slot_t   mem_q, mem_d;
    // WB only needs to know whether and where to write; its class is spent.
    logic        wb_valid_q, wb_valid_d;
    gpr_addr_t   wb_waddr_q, wb_waddr_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic exe_ready;
    logic exe_hold;
    logic hazard1;
    logic hazard2;
    logic id_stall;

    // A LONG op is forwardable only in the cycle its unit reports done; loads
    // are not forwardable until they reach MEM.
    assign exe_ready = !exe_q.valid || (exe_q.waddr == '0)
                    || (exe_q.wclass == GPR_CLASS_EXE)
                    || ((exe_q.wclass == GPR_CLASS_LONG) && i_LONG_done);

    assign exe_hold = exe_q.valid && (exe_q.wclass == GPR_CLASS_LONG) && !i_LONG_done;

    gpr_src_check u_src_check1 (
        .i_ren       (i_ID_ren1),
        .i_raddr     (i_ID_raddr1),
        .i_exe_valid (exe_q.valid),
        .i_exe_waddr (exe_q.waddr),
        .i_exe_ready (exe_ready),
        .o_hazard    (hazard1)
    );

    gpr_src_check u_src_check2 (
        .i_ren       (i_ID_ren2),
        .i_raddr     (i_ID_raddr2),
        .i_exe_valid (exe_q.valid),
        .i_exe_waddr (exe_q.waddr),
        .i_exe_ready (exe_ready),
        .o_hazard    (hazard2)
    );

    // A flush squashes the ID instruction, so it must not also stall it.
    assign id_stall = i_ID_valid && (hazard1 || hazard2 || exe_hold) && !i_flush;

    assign o_ID_stall              = id_stall;
    assign o_EXE_hold              = exe_hold;
    assign o_LONG_abort            = i_flush && exe_hold;
    assign o_EXE_get_result_in_EXE = exe_ready;
    assign o_EXE_waddr             = exe_q.waddr;
    // Loads return data in MEM and LONG results are captured before leaving EXE.
    assign o_MEM_get_result_in_MEM = 1'b1;
    assign o_MEM_waddr             = mem_q.waddr;
    assign o_WB_wen                = wb_valid_q && (wb_waddr_q != '0);
    assign o_WB_waddr              = wb_waddr_q;
    assign o_stall_cycles          = stall_cycles_q;

    // Next-state for the slots and the saturating stall counter.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can leave it unassigned and infer a latch.
        exe_d          = exe_q;
        mem_d          = exe_hold ? GPR_SLOT_EMPTY : exe_q;
        wb_valid_d     = mem_q.valid;
        wb_waddr_d     = mem_q.waddr;
        stall_cycles_d = stall_cycles_q;

        if (i_flush) begin
            exe_d = GPR_SLOT_EMPTY;
        end else if (exe_hold) begin
            exe_d = exe_q;
        end else if (id_stall || !i_ID_valid) begin
            exe_d = GPR_SLOT_EMPTY;
        end else begin
            exe_d = gpr_slot_from_id(gpr_class_e'(i_ID_wclass), i_ID_waddr);
        end

        if (id_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Slot and counter registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            exe_q          <= GPR_SLOT_EMPTY;
            mem_q          <= GPR_SLOT_EMPTY;
            wb_valid_q     <= 1'b0;
            wb_waddr_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            exe_q          <= exe_d;
            mem_q          <= mem_d;
            wb_valid_q     <= wb_valid_d;
            wb_waddr_q     <= wb_waddr_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_gpr_hazard_tracker.sv
// Directed bench for gpr_hazard_tracker: inputs change just after the falling
// edge and outputs are compared 1 ns later, well away from the rising edge.
module tb_gpr_hazard_tracker;
    import gpr_hazard_tracker_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ID_valid;
    logic [1:0]  i_ID_wclass;
    logic [4:0]  i_ID_waddr;
    logic        i_ID_ren1, i_ID_ren2;
    logic [4:0]  i_ID_raddr1, i_ID_raddr2;
    logic        i_LONG_done;
    logic        i_flush;
    logic        o_ID_stall, o_EXE_hold, o_LONG_abort;
    logic        o_EXE_get_result_in_EXE, o_MEM_get_result_in_MEM;
    logic [4:0]  o_EXE_waddr, o_MEM_waddr, o_WB_waddr;
    logic        o_WB_wen;
    logic [31:0] o_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    gpr_hazard_tracker dut (
        .i_clk                   (i_clk),
        .i_rst_n                 (i_rst_n),
        .i_ID_valid              (i_ID_valid),
        .i_ID_wclass             (i_ID_wclass),
        .i_ID_waddr              (i_ID_waddr),
        .i_ID_ren1               (i_ID_ren1),
        .i_ID_ren2               (i_ID_ren2),
        .i_ID_raddr1             (i_ID_raddr1),
        .i_ID_raddr2             (i_ID_raddr2),
        .i_LONG_done             (i_LONG_done),
        .i_flush                 (i_flush),
        .o_ID_stall              (o_ID_stall),
        .o_EXE_hold              (o_EXE_hold),
        .o_LONG_abort            (o_LONG_abort),
        .o_EXE_get_result_in_EXE (o_EXE_get_result_in_EXE),
        .o_EXE_waddr             (o_EXE_waddr),
        .o_MEM_get_result_in_MEM (o_MEM_get_result_in_MEM),
        .o_MEM_waddr             (o_MEM_waddr),
        .o_WB_wen                (o_WB_wen),
        .o_WB_waddr              (o_WB_waddr),
        .o_stall_cycles          (o_stall_cycles)
    );

    always #5 i_clk = ~i_clk;

    task automatic issue(input logic v, input gpr_class_e c, input logic [4:0] wa,
                         input logic r1, input logic [4:0] ra1,
                         input logic r2, input logic [4:0] ra2);
        i_ID_valid  = v;
        i_ID_wclass = c;
        i_ID_waddr  = wa;
        i_ID_ren1   = r1;
        i_ID_raddr1 = ra1;
        i_ID_ren2   = r2;
        i_ID_raddr2 = ra2;
    endtask

    task automatic idle();
        issue(1'b0, GPR_CLASS_NONE, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        i_LONG_done = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle();
        #2;
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %0b want 0", o_EXE_hold); end
        n_checks++; if (o_LONG_abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got %0b want 0", o_LONG_abort); end
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b1) begin n_fail++; $display("FAIL rst_exe_flag: got %0b want 1", o_EXE_get_result_in_EXE); end
        n_checks++; if (o_MEM_get_result_in_MEM !== 1'b1) begin n_fail++; $display("FAIL rst_mem_flag: got %0b want 1", o_MEM_get_result_in_MEM); end
        n_checks++; if (o_EXE_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_exe_waddr: got %0d want 0", o_EXE_waddr); end
        n_checks++; if (o_MEM_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_mem_waddr: got %0d want 0", o_MEM_waddr); end
        n_checks++; if (o_WB_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wb_wen: got %0b want 0", o_WB_wen); end
        n_checks++; if (o_WB_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_wb_waddr: got %0d want 0", o_WB_waddr); end
        n_checks++; if (o_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", o_stall_cycles); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_alu_chain();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_NONE, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0); #1;
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_exe_waddr: got %0d want 5", o_EXE_waddr); end
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b1) begin n_fail++; $display("FAIL alu_exe_flag: got %0b want 1", o_EXE_get_result_in_EXE); end
        @(negedge i_clk); idle(); #1;
        n_checks++; if (o_MEM_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_mem_waddr: got %0d want 5", o_MEM_waddr); end
        n_checks++; if (o_EXE_waddr !== 5'd0) begin n_fail++; $display("FAIL alu_none_waddr: got %0d want 0", o_EXE_waddr); end
        @(negedge i_clk); #1;
        n_checks++; if (o_WB_wen !== 1'b1) begin n_fail++; $display("FAIL alu_wb_wen: got %0b want 1", o_WB_wen); end
        n_checks++; if (o_WB_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_wb_waddr: got %0d want 5", o_WB_waddr); end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_load_use();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_MEM, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd10, 1'b0, 5'd0, 1'b1, 5'd8); #1;
        n_checks++; if (o_ID_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", o_ID_stall); end
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b0) begin n_fail++; $display("FAIL lu_exe_flag: got %0b want 0", o_EXE_get_result_in_EXE); end
        @(negedge i_clk); #1;
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_waddr !== 5'd0) begin n_fail++; $display("FAIL lu_bubble: got %0d want 0", o_EXE_waddr); end
        n_checks++; if (o_MEM_waddr !== 5'd8) begin n_fail++; $display("FAIL lu_mem_waddr: got %0d want 8", o_MEM_waddr); end
        n_checks++; if (o_MEM_get_result_in_MEM !== 1'b1) begin n_fail++; $display("FAIL lu_mem_flag: got %0b want 1", o_MEM_get_result_in_MEM); end
        n_checks++; if (o_stall_cycles !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", o_stall_cycles); end
        @(negedge i_clk); idle(); #1;
        n_checks++; if (o_EXE_waddr !== 5'd10) begin n_fail++; $display("FAIL lu_consumer: got %0d want 10", o_EXE_waddr); end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_divide();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_LONG, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (o_EXE_hold !== 1'b1) begin n_fail++; $display("FAIL div_hold[%0d]: got %0b want 1", i, o_EXE_hold); end
            n_checks++; if (o_ID_stall !== 1'b1) begin n_fail++; $display("FAIL div_stall[%0d]: got %0b want 1", i, o_ID_stall); end
            n_checks++; if (o_EXE_get_result_in_EXE !== 1'b0) begin n_fail++; $display("FAIL div_flag[%0d]: got %0b want 0", i, o_EXE_get_result_in_EXE); end
            n_checks++; if (o_MEM_waddr !== 5'd0) begin n_fail++; $display("FAIL div_mem_bubble[%0d]: got %0d want 0", i, o_MEM_waddr); end
            @(negedge i_clk);
        end
        i_LONG_done = 1'b1; #1;
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b1) begin n_fail++; $display("FAIL div_done_flag: got %0b want 1", o_EXE_get_result_in_EXE); end
        n_checks++; if (o_EXE_hold !== 1'b0) begin n_fail++; $display("FAIL div_done_hold: got %0b want 0", o_EXE_hold); end
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL div_done_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_MEM_waddr !== 5'd0) begin n_fail++; $display("FAIL div_done_mem: got %0d want 0", o_MEM_waddr); end
        @(negedge i_clk); idle(); #1;
        n_checks++; if (o_MEM_waddr !== 5'd3) begin n_fail++; $display("FAIL div_mem_waddr: got %0d want 3", o_MEM_waddr); end
        n_checks++; if (o_EXE_waddr !== 5'd4) begin n_fail++; $display("FAIL div_dep_exe: got %0d want 4", o_EXE_waddr); end
        n_checks++; if (o_stall_cycles !== 32'd5) begin n_fail++; $display("FAIL div_cnt: got %0d want 5", o_stall_cycles); end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_zero_reg();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_MEM, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_NONE, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0); #1;
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b1) begin n_fail++; $display("FAIL zero_flag: got %0b want 1", o_EXE_get_result_in_EXE); end
        @(negedge i_clk); idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (o_WB_wen !== 1'b0) begin n_fail++; $display("FAIL zero_wb_wen[%0d]: got %0b want 0", i, o_WB_wen); end
            @(negedge i_clk);
        end
        n_checks++; if (o_stall_cycles !== 32'd5) begin n_fail++; $display("FAIL zero_cnt: got %0d want 5", o_stall_cycles); end
    endtask

    task automatic test_flush_divide();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_MEM, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_LONG, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd11, 1'b1, 5'd7, 1'b0, 5'd0); i_flush = 1'b1; #1;
        n_checks++; if (o_LONG_abort !== 1'b1) begin n_fail++; $display("FAIL fl_abort: got %0b want 1", o_LONG_abort); end
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_hold !== 1'b1) begin n_fail++; $display("FAIL fl_hold: got %0b want 1", o_EXE_hold); end
        n_checks++; if (o_MEM_waddr !== 5'd9) begin n_fail++; $display("FAIL fl_mem_waddr: got %0d want 9", o_MEM_waddr); end
        @(negedge i_clk); idle(); #1;
        n_checks++; if (o_LONG_abort !== 1'b0) begin n_fail++; $display("FAIL fl_abort_end: got %0b want 0", o_LONG_abort); end
        n_checks++; if (o_EXE_waddr !== 5'd0) begin n_fail++; $display("FAIL fl_exe_empty: got %0d want 0", o_EXE_waddr); end
        n_checks++; if (o_EXE_hold !== 1'b0) begin n_fail++; $display("FAIL fl_hold_end: got %0b want 0", o_EXE_hold); end
        n_checks++; if (o_WB_wen !== 1'b1) begin n_fail++; $display("FAIL fl_wb_wen: got %0b want 1", o_WB_wen); end
        n_checks++; if (o_WB_waddr !== 5'd9) begin n_fail++; $display("FAIL fl_wb_waddr: got %0d want 9", o_WB_waddr); end
        n_checks++; if (o_stall_cycles !== 32'd5) begin n_fail++; $display("FAIL fl_cnt: got %0d want 5", o_stall_cycles); end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_reset_mid_pipeline();
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_LONG, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge i_clk); issue(1'b1, GPR_CLASS_EXE, 5'd12, 1'b1, 5'd3, 1'b0, 5'd0); #1;
        n_checks++; if (o_WB_waddr !== 5'd1) begin n_fail++; $display("FAIL mr_pre_wb: got %0d want 1", o_WB_waddr); end
        n_checks++; if (o_MEM_waddr !== 5'd2) begin n_fail++; $display("FAIL mr_pre_mem: got %0d want 2", o_MEM_waddr); end
        n_checks++; if (o_EXE_waddr !== 5'd3) begin n_fail++; $display("FAIL mr_pre_exe: got %0d want 3", o_EXE_waddr); end
        n_checks++; if (o_ID_stall !== 1'b1) begin n_fail++; $display("FAIL mr_pre_stall: got %0b want 1", o_ID_stall); end
        #1; i_rst_n = 1'b0; #1;
        n_checks++; if (o_ID_stall !== 1'b0) begin n_fail++; $display("FAIL mr_stall: got %0b want 0", o_ID_stall); end
        n_checks++; if (o_EXE_hold !== 1'b0) begin n_fail++; $display("FAIL mr_hold: got %0b want 0", o_EXE_hold); end
        n_checks++; if (o_LONG_abort !== 1'b0) begin n_fail++; $display("FAIL mr_abort: got %0b want 0", o_LONG_abort); end
        n_checks++; if (o_EXE_get_result_in_EXE !== 1'b1) begin n_fail++; $display("FAIL mr_exe_flag: got %0b want 1", o_EXE_get_result_in_EXE); end
        n_checks++; if (o_EXE_waddr !== 5'd0) begin n_fail++; $display("FAIL mr_exe_waddr: got %0d want 0", o_EXE_waddr); end
        n_checks++; if (o_MEM_waddr !== 5'd0) begin n_fail++; $display("FAIL mr_mem_waddr: got %0d want 0", o_MEM_waddr); end
        n_checks++; if (o_WB_wen !== 1'b0) begin n_fail++; $display("FAIL mr_wb_wen: got %0b want 0", o_WB_wen); end
        n_checks++; if (o_WB_waddr !== 5'd0) begin n_fail++; $display("FAIL mr_wb_waddr: got %0d want 0", o_WB_waddr); end
        n_checks++; if (o_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL mr_cnt: got %0d want 0", o_stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_divide();
        test_zero_reg();
        test_flush_divide();
        test_reset_mid_pipeline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
